// File: rtl/macc_pkg.sv
// Shared types and constants for the matrix read path feeding the MAC datapath.
package macc_pkg;

  localparam int STRM_FIFO_DEPTH = 3;
  localparam int STRM_DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } strm_state_t;

  typedef struct packed {
    logic [STRM_DATA_W-1:0] data;
    logic                   last_col;
    logic                   last;
  } strm_elem_t;

  // Circular pointer step for the 3-entry element FIFO.
  function automatic logic [1:0] strm_ptr_next(input logic [1:0] ptr);
    return (ptr == 2'(STRM_FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/elem_fifo.sv
// Three-entry skid FIFO of matrix elements with occupancy, used between memory
// read return and the output stream.
module elem_fifo
  import macc_pkg::*;
#(
  parameter type elem_t = strm_elem_t
) (
  input  logic       CLK,
  input  logic       RST_L,
  input  logic       push,
  input  elem_t      push_elem,
  input  logic       pop,
  output elem_t      head,
  output logic [1:0] occupancy
);

  elem_t      mem [STRM_FIFO_DEPTH];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (occupancy != 2'd0);
  assign do_push = push && ((occupancy != 2'(STRM_FIFO_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      occupancy <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= strm_ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= strm_ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while occupancy is nonzero.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_elem;
  end

endmodule

// File: rtl/matrix_streamer.sv
// Row-major matrix read initiator: issues re pulses, tags each element with
// end-of-row / end-of-matrix and streams it out through a skid FIFO.
module matrix_streamer
  import macc_pkg::*;
#(
  parameter int ADDR_MSB = 11,
  parameter int DATA_W   = STRM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_L,
  input  logic              start,
  input  logic [ADDR_MSB:0] max_row_count,
  input  logic [ADDR_MSB:0] max_col_count,
  input  logic              hold,
  output logic              re,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last_col;
    logic              last;
  } elem_t;

  strm_state_t       state_q;
  logic [ADDR_MSB:0] max_row_q;
  logic [ADDR_MSB:0] max_col_q;
  logic [ADDR_MSB:0] row_q;
  logic [ADDR_MSB:0] col_q;
  logic              inflight_valid_q;
  logic              inflight_last_col_q;
  logic              inflight_last_q;
  logic              done_q;

  logic [1:0]        fifo_occ;
  elem_t             fifo_head;
  elem_t             push_elem;
  logic              handshake;
  logic              issue_last_col;
  logic              issue_last;

  assign issue_last_col = (col_q == max_col_q);
  assign issue_last     = issue_last_col && (row_q == max_row_q);

  // Throttle on slots already committed (stored plus in flight) so a stalled
  // consumer can never overflow the FIFO; out_ready is deliberately not used.
  assign re = (state_q == RUN) && !hold &&
              (({1'b0, fifo_occ} + {2'b0, inflight_valid_q}) < 3'(STRM_FIFO_DEPTH));

  assign out_valid    = (fifo_occ != 2'd0);
  assign handshake    = out_valid && out_ready;
  assign out_data     = out_valid ? fifo_head.data : '0;
  assign out_last_col = out_valid && fifo_head.last_col;
  assign out_last     = out_valid && fifo_head.last;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  assign push_elem = '{data: rd_data, last_col: inflight_last_col_q, last: inflight_last_q};

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q   <= IDLE;
      max_row_q <= '0;
      max_col_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            max_row_q <= max_row_count;
            max_col_q <= max_col_count;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (re) begin
            if (issue_last_col) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (issue_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (handshake && fifo_head.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-stage request tag pipeline matching the memory's single-cycle read latency.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      inflight_valid_q    <= 1'b0;
      inflight_last_col_q <= 1'b0;
      inflight_last_q     <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      inflight_valid_q    <= re;
      inflight_last_col_q <= re && issue_last_col;
      inflight_last_q     <= re && issue_last;
      done_q              <= (state_q == DRAIN) && handshake && fifo_head.last;
    end
  end

  elem_fifo #(.elem_t(elem_t)) u_fifo (
    .CLK       (CLK),
    .RST_L     (RST_L),
    .push      (inflight_valid_q),
    .push_elem (push_elem),
    .pop       (handshake),
    .head      (fifo_head),
    .occupancy (fifo_occ)
  );

endmodule

// File: tb/tb_matrix_streamer.sv
// Self-checking bench for matrix_streamer: memory model, stream monitor and
// a row-major reference of the expected element sequence.
module tb_matrix_streamer;

  logic        CLK = 1'b0;
  logic        RST_L = 1'b0;
  logic        start = 1'b0;
  logic [11:0] max_row_count = '0;
  logic [11:0] max_col_count = '0;
  logic        hold = 1'b0;
  logic        re;
  logic [15:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last_col;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  logic [15:0] mem [256];
  int mem_idx = 0;
  int mem_base = 0;

  int          re_cyc[$];
  int          hs_cyc[$];
  logic [15:0] hs_data[$];
  logic        hs_lc[$];
  logic        hs_last[$];
  int          done_cyc[$];
  int          busy_cnt = 0;
  int          violations = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_elem = '0;

  int t0, re_b, hs_b, done_b, busy_b, viol_b;

  matrix_streamer dut (
    .CLK(CLK), .RST_L(RST_L), .start(start),
    .max_row_count(max_row_count), .max_col_count(max_col_count),
    .hold(hold), .re(re), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_col(out_last_col), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory returns the next stored word one cycle after each re pulse.
  always @(posedge CLK) begin
    if (re) begin
      rd_data <= mem[(mem_idx - mem_base) & 255];
      mem_idx <= mem_idx + 1;
    end
  end

  always @(negedge CLK) begin
    if (RST_L) begin
      if (re) re_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(out_data);
        hs_lc.push_back(out_last_col);
        hs_last.push_back(out_last);
      end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt <= busy_cnt + 1;
      if (prev_stall && (!out_valid || {out_data, out_last_col, out_last} != prev_elem))
        violations <= violations + 1;
      prev_stall <= out_valid && !out_ready;
      prev_elem  <= {out_data, out_last_col, out_last};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Reference element i of a rows x cols read: memory word i, flags from position.
  function automatic logic [17:0] exp_elem(int i, int rows, int cols);
    logic lc, lst;
    lc  = (i % cols) == (cols - 1);
    lst = (i == rows * cols - 1);
    return {mem[i], lc, lst};
  endfunction

  function automatic logic [17:0] obs_elem(int k);
    return {hs_data[k], hs_lc[k], hs_last[k]};
  endfunction

  task automatic start_read(input int rows_m1, input int cols_m1);
    for (int i = 0; i < (rows_m1 + 1) * (cols_m1 + 1); i++) mem[i] = 16'($urandom);
    @(posedge CLK); #1;
    mem_base      = mem_idx;
    re_b          = re_cyc.size();
    hs_b          = hs_cyc.size();
    done_b        = done_cyc.size();
    busy_b        = busy_cnt;
    viol_b        = violations;
    t0            = cyc;
    start         = 1'b1;
    max_row_count = 12'(rows_m1);
    max_col_count = 12'(cols_m1);
    @(posedge CLK); #1;
    start         = 1'b0;
    max_row_count = 12'($urandom);
    max_col_count = 12'($urandom);
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(posedge CLK); #2;
      if (done_cyc.size() > done_b) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({re, out_valid, out_last_col, out_last, busy, done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {re, out_valid, out_last_col, out_last, busy, done});
    end
    checks++;
    if (out_data !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0000", out_data);
    end
    @(posedge CLK); #1;
    RST_L = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_2x3;
    bit ok;
    out_ready = 1'b1;
    hold      = 1'b0;
    start_read(1, 2);
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL 2x3_done_timeout: got none expected done"); end
    checks++;
    if (re_cyc.size() - re_b !== 6) begin
      errors++; $display("[TB] FAIL 2x3_re_count: got %0d expected 6", re_cyc.size() - re_b);
    end
    for (int k = 0; k < 6 && re_b + k < re_cyc.size(); k++) begin
      checks++;
      if (re_cyc[re_b + k] - t0 !== k + 1) begin
        errors++; $display("[TB] FAIL 2x3_re_cycle[%0d]: got %0d expected %0d", k, re_cyc[re_b + k] - t0, k + 1);
      end
    end
    checks++;
    if (hs_cyc.size() - hs_b !== 6) begin
      errors++; $display("[TB] FAIL 2x3_out_count: got %0d expected 6", hs_cyc.size() - hs_b);
    end
    for (int k = 0; k < 6 && hs_b + k < hs_cyc.size(); k++) begin
      checks++;
      if (hs_cyc[hs_b + k] - t0 !== k + 3) begin
        errors++; $display("[TB] FAIL 2x3_out_cycle[%0d]: got %0d expected %0d", k, hs_cyc[hs_b + k] - t0, k + 3);
      end
      checks++;
      if (obs_elem(hs_b + k) !== exp_elem(k, 2, 3)) begin
        errors++; $display("[TB] FAIL 2x3_elem[%0d]: got %h expected %h", k, obs_elem(hs_b + k), exp_elem(k, 2, 3));
      end
    end
    if (ok) begin
      checks++;
      if (done_cyc[done_b] - t0 !== 9) begin
        errors++; $display("[TB] FAIL 2x3_done_cycle: got %0d expected 9", done_cyc[done_b] - t0);
      end
    end
    checks++;
    if (busy_cnt - busy_b !== 8) begin
      errors++; $display("[TB] FAIL 2x3_busy_cycles: got %0d expected 8", busy_cnt - busy_b);
    end
  endtask

  task automatic test_1x1;
    bit ok;
    out_ready = 1'b1;
    start_read(0, 0);
    wait_done(20, ok);
    repeat (2) @(posedge CLK);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL 1x1_done_timeout: got none expected done"); end
    checks++;
    if (re_cyc.size() - re_b !== 1) begin
      errors++; $display("[TB] FAIL 1x1_re_count: got %0d expected 1", re_cyc.size() - re_b);
    end
    checks++;
    if (hs_cyc.size() - hs_b !== 1) begin
      errors++; $display("[TB] FAIL 1x1_out_count: got %0d expected 1", hs_cyc.size() - hs_b);
    end else begin
      checks++;
      if (obs_elem(hs_b) !== {mem[0], 1'b1, 1'b1}) begin
        errors++; $display("[TB] FAIL 1x1_elem: got %h expected %h", obs_elem(hs_b), {mem[0], 2'b11});
      end
    end
    checks++;
    if (busy_cnt - busy_b !== 3) begin
      errors++; $display("[TB] FAIL 1x1_busy_cycles: got %0d expected 3", busy_cnt - busy_b);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit have;
    logic [15:0] held;
    have = 1'b0;
    held = '0;
    out_ready = 1'b0;
    start_read(3, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (out_valid) begin
        if (!have) begin
          have = 1'b1;
          held = out_data;
        end else begin
          checks++;
          if (out_data !== held) begin
            errors++; $display("[TB] FAIL stall_data_stable: got %h expected %h", out_data, held);
          end
        end
      end
    end
    checks++;
    if (re_cyc.size() - re_b !== 3) begin
      errors++; $display("[TB] FAIL stall_re_count: got %0d expected 3", re_cyc.size() - re_b);
    end
    checks++;
    if (out_data !== mem[0]) begin
      errors++; $display("[TB] FAIL stall_head: got %h expected %h", out_data, mem[0]);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    wait_done(80, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL stall_done_timeout: got none expected done"); end
    checks++;
    if (hs_cyc.size() - hs_b !== 16) begin
      errors++; $display("[TB] FAIL stall_out_count: got %0d expected 16", hs_cyc.size() - hs_b);
    end
    for (int k = 0; k < 16 && hs_b + k < hs_cyc.size(); k++) begin
      checks++;
      if (obs_elem(hs_b + k) !== exp_elem(k, 4, 4)) begin
        errors++; $display("[TB] FAIL stall_elem[%0d]: got %h expected %h", k, obs_elem(hs_b + k), exp_elem(k, 4, 4));
      end
      if (k > 0) begin
        checks++;
        if (hs_cyc[hs_b + k] - hs_cyc[hs_b + k - 1] !== 1) begin
          errors++; $display("[TB] FAIL stall_gap[%0d]: got %0d expected 1", k, hs_cyc[hs_b + k] - hs_cyc[hs_b + k - 1]);
        end
      end
    end
  endtask

  task automatic test_hold;
    bit ok;
    int bad_re;
    out_ready = 1'b1;
    start_read(2, 3);
    @(posedge CLK); #1;
    @(posedge CLK); #1; hold = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    @(posedge CLK); #1; hold = 1'b0;
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL hold_done_timeout: got none expected done"); end
    bad_re = 0;
    for (int k = re_b; k < re_cyc.size(); k++)
      if (re_cyc[k] - t0 >= 3 && re_cyc[k] - t0 <= 5) bad_re++;
    checks++;
    if (bad_re !== 0) begin errors++; $display("[TB] FAIL hold_re_during_hold: got %0d expected 0", bad_re); end
    checks++;
    if (hs_cyc.size() - hs_b !== 12) begin
      errors++; $display("[TB] FAIL hold_out_count: got %0d expected 12", hs_cyc.size() - hs_b);
    end
    for (int k = 0; k < 12 && hs_b + k < hs_cyc.size(); k++) begin
      checks++;
      if (obs_elem(hs_b + k) !== exp_elem(k, 3, 4)) begin
        errors++; $display("[TB] FAIL hold_elem[%0d]: got %h expected %h", k, obs_elem(hs_b + k), exp_elem(k, 3, 4));
      end
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    out_ready = 1'b1;
    start_read(1, 2);
    @(posedge CLK); #1;
    start = 1'b1; max_row_count = 12'd3; max_col_count = 12'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(40, ok);
    repeat (4) @(posedge CLK);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL restart_done_timeout: got none expected done"); end
    checks++;
    if (hs_cyc.size() - hs_b !== 6) begin
      errors++; $display("[TB] FAIL restart_out_count: got %0d expected 6", hs_cyc.size() - hs_b);
    end
    for (int k = 0; k < 6 && hs_b + k < hs_cyc.size(); k++) begin
      checks++;
      if (obs_elem(hs_b + k) !== exp_elem(k, 2, 3)) begin
        errors++; $display("[TB] FAIL restart_elem[%0d]: got %h expected %h", k, obs_elem(hs_b + k), exp_elem(k, 2, 3));
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    bit ok;
    out_ready = 1'b0;
    start_read(0, 1);
    repeat (4) begin @(posedge CLK); #1; end
    checks++;
    if ({busy, re, out_valid} !== 3'b101) begin
      errors++; $display("[TB] FAIL drain_state: got busy/re/valid %b expected 101", {busy, re, out_valid});
    end
    RST_L = 1'b0;
    #1;
    checks++;
    if ({re, out_valid, out_last_col, out_last, busy, done, out_data} !== 22'b0) begin
      errors++; $display("[TB] FAIL drain_reset_outputs: got %h expected 0",
                         {re, out_valid, out_last_col, out_last, busy, done, out_data});
    end
    @(posedge CLK); #1;
    RST_L = 1'b1;
    out_ready = 1'b1;
    start_read(1, 1);
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL post_reset_done_timeout: got none expected done"); end
    checks++;
    if (hs_cyc.size() - hs_b !== 4) begin
      errors++; $display("[TB] FAIL post_reset_out_count: got %0d expected 4", hs_cyc.size() - hs_b);
    end
    for (int k = 0; k < 4 && hs_b + k < hs_cyc.size(); k++) begin
      checks++;
      if (obs_elem(hs_b + k) !== exp_elem(k, 2, 2)) begin
        errors++; $display("[TB] FAIL post_reset_elem[%0d]: got %h expected %h", k, obs_elem(hs_b + k), exp_elem(k, 2, 2));
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int rows, cols;
    for (int it = 0; it < 6; it++) begin
      rows = $urandom_range(1, 4);
      cols = $urandom_range(1, 5);
      out_ready = 1'b1;
      hold = 1'b0;
      start_read(rows - 1, cols - 1);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        hold      = ($urandom_range(0, 4) == 0);
        @(posedge CLK); #1;
        if (done_cyc.size() > done_b) ok = 1'b1;
      end
      out_ready = 1'b1;
      hold = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done_timeout: got none expected done", it); end
      checks++;
      if (hs_cyc.size() - hs_b !== rows * cols) begin
        errors++; $display("[TB] FAIL rand%0d_out_count: got %0d expected %0d", it, hs_cyc.size() - hs_b, rows * cols);
      end
      for (int k = 0; k < rows * cols && hs_b + k < hs_cyc.size(); k++) begin
        checks++;
        if (obs_elem(hs_b + k) !== exp_elem(k, rows, cols)) begin
          errors++; $display("[TB] FAIL rand%0d_elem[%0d]: got %h expected %h", it, k, obs_elem(hs_b + k), exp_elem(k, rows, cols));
        end
      end
      checks++;
      if (violations - viol_b !== 0) begin
        errors++; $display("[TB] FAIL rand%0d_stall_stability: got %0d violations expected 0", it, violations - viol_b);
      end
      repeat (2) @(posedge CLK);
    end
  endtask

  initial begin
    test_reset;
    test_2x3;
    test_1x1;
    test_backpressure;
    test_hold;
    test_start_ignored;
    test_reset_mid_drain;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
